// File: rtl/branch_resolve_unit.sv
// Carries IF-stage branch predictions through IF/ID and ID/EX and checks them in EX.
// Issues a registered redirect and flush on a wrong prediction and counts branches and mispredicts.
module branch_resolve_unit #(
    parameter int CNT_WIDTH  = 32,
    parameter int SQUASH_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_if,
    input  logic                 pred_taken_if,
    input  logic [29:0]          pred_target_if,
    input  logic                 stall_pc,
    input  logic                 cond_jump_instr_ex,
    input  logic                 uncond_jump_instr_ex,
    input  logic                 actual_taken_ex,
    input  logic [29:0]          actual_target_ex,
    output logic                 mispredict,
    output logic [29:0]          redirect_pc,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 cond_resolved,
    output logic                 cond_taken,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    localparam int SQW = (SQUASH_CYC > 1) ? $clog2(SQUASH_CYC + 1) : 1;
    localparam logic [SQW-1:0] SQ_LAST = SQW'(SQUASH_CYC);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t         state, state_n;
    logic [SQW-1:0] sq_cnt, sq_cnt_n;

    logic        vld_p1, pred_taken_p1;
    logic [29:0] pc_p1, pred_target_p1;
    logic        vld_p2, pred_taken_p2;
    logic [29:0] pc_p2, pred_target_p2;

    logic        is_br, taken, eval, wrong, mis_n, cond_only;
    logic [29:0] correct_pc;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_if[1:0];

    // IF -> IF/ID: flush clears valid even while stalled
    always_ff @(posedge clk) begin
        if (rst)             vld_p1 <= 1'b0;
        else if (mispredict) vld_p1 <= 1'b0;
        else if (!stall_pc)  vld_p1 <= 1'b1;
        if (!stall_pc) begin
            pc_p1          <= pc_if[31:2];
            pred_taken_p1  <= pred_taken_if;
            pred_target_p1 <= pred_target_if;
        end
    end

    // IF/ID -> ID/EX: stall or flush inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1 && !stall_pc && !mispredict;
        if (!stall_pc) begin
            pc_p2          <= pc_p1;
            pred_taken_p2  <= pred_taken_p1;
            pred_target_p2 <= pred_target_p1;
        end
    end

    // EX: compare prediction with resolved outcome
    always_comb begin
        is_br      = cond_jump_instr_ex | uncond_jump_instr_ex;
        taken      = uncond_jump_instr_ex | (cond_jump_instr_ex & actual_taken_ex);
        cond_only  = cond_jump_instr_ex & ~uncond_jump_instr_ex;
        eval       = vld_p2 && (state == RUN);
        wrong      = pred_taken_p2;
        if (is_br)
            wrong = (pred_taken_p2 != taken) ||
                    (taken && pred_taken_p2 && (pred_target_p2 != actual_target_ex));
        mis_n      = eval && wrong;
        correct_pc = taken ? actual_target_ex : pc_p2 + 30'd1;
    end

    always_comb begin
        state_n  = state;
        sq_cnt_n = sq_cnt;
        case (state)
            RUN: begin
                if (mis_n) begin
                    state_n  = SQUASH;
                    sq_cnt_n = SQW'(1);
                end
            end
            SQUASH: begin
                if (sq_cnt >= SQ_LAST) begin
                    state_n  = RUN;
                    sq_cnt_n = '0;
                end else begin
                    sq_cnt_n = sq_cnt + SQW'(1);
                end
            end
            default: begin
                state_n  = RUN;
                sq_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_n;
            sq_cnt <= sq_cnt_n;
        end
    end

    // EX -> registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            cond_resolved  <= 1'b0;
            cond_taken     <= 1'b0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            mispredict    <= mis_n;
            redirect_pc   <= mis_n ? correct_pc : 30'd0;
            cond_resolved <= eval && cond_only;
            cond_taken    <= eval && cond_only && actual_taken_ex;
            if (eval && is_br) branch_cnt     <= branch_cnt + 1'b1;
            if (mis_n)         mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

    assign flush_if_id = mispredict;
    assign flush_id_ex = mispredict;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: prediction checks, squash, stall, counter wrap and reset.
module tb_branch_resolve_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc_if;
    logic          pred_taken_if;
    logic [29:0]   pred_target_if;
    logic          stall_pc;
    logic          cond_jump_instr_ex;
    logic          uncond_jump_instr_ex;
    logic          actual_taken_ex;
    logic [29:0]   actual_target_ex;
    logic          mispredict;
    logic [29:0]   redirect_pc;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic          cond_resolved;
    logic          cond_taken;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    int vectors = 0;
    int miscompares = 0;

    branch_resolve_unit #(.CNT_WIDTH(CW), .SQUASH_CYC(1)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .pred_taken_if(pred_taken_if),
        .pred_target_if(pred_target_if), .stall_pc(stall_pc),
        .cond_jump_instr_ex(cond_jump_instr_ex), .uncond_jump_instr_ex(uncond_jump_instr_ex),
        .actual_taken_ex(actual_taken_ex), .actual_target_ex(actual_target_ex),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .cond_resolved(cond_resolved), .cond_taken(cond_taken),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic c, input logic u, input logic at, input logic [29:0] atgt);
        cond_jump_instr_ex   = c;
        uncond_jump_instr_ex = u;
        actual_taken_ex      = at;
        actual_target_ex     = atgt;
    endtask

    // Fetch one instruction, follow it with a plain filler, resolve it in EX.
    // Returns just after the edge that registers its outcome.
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [29:0] ptgt,
                         input logic c, input logic u, input logic at, input logic [29:0] atgt);
        pc_if = pc; pred_taken_if = pt; pred_target_if = ptgt;
        step();
        pc_if = pc + 32'd4; pred_taken_if = 1'b0; pred_target_if = '0;
        step();
        set_ex(c, u, at, atgt);
        step();
        set_ex(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
        check({tag, "_redirect"}, {2'd0, redirect_pc}, 32'd0);
        check({tag, "_flush_if_id"}, {31'd0, flush_if_id}, 32'd0);
        check({tag, "_flush_id_ex"}, {31'd0, flush_id_ex}, 32'd0);
        check({tag, "_cond_resolved"}, {31'd0, cond_resolved}, 32'd0);
        check({tag, "_cond_taken"}, {31'd0, cond_taken}, 32'd0);
        check({tag, "_branch_cnt"}, {28'd0, branch_cnt}, 32'd0);
        check({tag, "_mispredict_cnt"}, {28'd0, mispredict_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall_pc = 1'b0;
        pc_if = '0; pred_taken_if = 1'b0; pred_target_if = '0;
        set_ex(1'b0, 1'b0, 1'b0, '0);
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // 1: correctly predicted taken conditional branch
        issue(32'h100, 1'b1, 30'h80, 1'b1, 1'b0, 1'b1, 30'h80);
        check("t1_mispredict", {31'd0, mispredict}, 32'd0);
        check("t1_cond_resolved", {31'd0, cond_resolved}, 32'd1);
        check("t1_cond_taken", {31'd0, cond_taken}, 32'd1);
        check("t1_branch_cnt", {28'd0, branch_cnt}, 32'd1);
        check("t1_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd0);
        step();
        check("t1_cond_resolved_pulse", {31'd0, cond_resolved}, 32'd0);

        // 2: predicted taken, actually not taken
        issue(32'h100, 1'b1, 30'h80, 1'b1, 1'b0, 1'b0, 30'h80);
        check("t2_mispredict", {31'd0, mispredict}, 32'd1);
        check("t2_redirect", {2'd0, redirect_pc}, 32'h41);
        check("t2_flush_if_id", {31'd0, flush_if_id}, 32'd1);
        check("t2_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        check("t2_cond_resolved", {31'd0, cond_resolved}, 32'd1);
        check("t2_cond_taken", {31'd0, cond_taken}, 32'd0);
        check("t2_branch_cnt", {28'd0, branch_cnt}, 32'd2);
        check("t2_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd1);
        step();
        check("t2_mispredict_pulse", {31'd0, mispredict}, 32'd0);

        // 3: unconditional jump with wrong target; wrong-path EX ignored
        issue(32'h50, 1'b1, 30'hC0, 1'b0, 1'b1, 1'b0, 30'h100);
        check("t3_mispredict", {31'd0, mispredict}, 32'd1);
        check("t3_redirect", {2'd0, redirect_pc}, 32'h100);
        check("t3_cond_resolved", {31'd0, cond_resolved}, 32'd0);
        check("t3_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        check("t3_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd2);
        set_ex(1'b1, 1'b0, 1'b1, 30'h55);
        step();
        set_ex(1'b0, 1'b0, 1'b0, '0);
        check("t3_squash_mispredict", {31'd0, mispredict}, 32'd0);
        check("t3_squash_cond_resolved", {31'd0, cond_resolved}, 32'd0);
        check("t3_squash_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        check("t3_squash_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd2);

        // 4: non-branch predicted taken (BTB alias)
        issue(32'h1FC, 1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0);
        check("t4_mispredict", {31'd0, mispredict}, 32'd1);
        check("t4_redirect", {2'd0, redirect_pc}, 32'h80);
        check("t4_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        check("t4_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd3);
        step();

        // 5: three-cycle stall while the branch sits in ID
        pc_if = 32'h180; pred_taken_if = 1'b1; pred_target_if = 30'h90;
        step();
        pc_if = 32'h184; pred_taken_if = 1'b0; pred_target_if = '0;
        stall_pc = 1'b1;
        step();
        set_ex(1'b1, 1'b0, 1'b1, 30'h90);
        step();
        check("t5_stall1_cond_resolved", {31'd0, cond_resolved}, 32'd0);
        step();
        check("t5_stall2_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        stall_pc = 1'b0;
        step();
        check("t5_release_cond_resolved", {31'd0, cond_resolved}, 32'd0);
        check("t5_release_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        step();
        set_ex(1'b0, 1'b0, 1'b0, '0);
        check("t5_eval_cond_resolved", {31'd0, cond_resolved}, 32'd1);
        check("t5_eval_cond_taken", {31'd0, cond_taken}, 32'd1);
        check("t5_eval_mispredict", {31'd0, mispredict}, 32'd0);
        check("t5_eval_branch_cnt", {28'd0, branch_cnt}, 32'd4);
        step();
        check("t5_once_cond_resolved", {31'd0, cond_resolved}, 32'd0);
        check("t5_once_branch_cnt", {28'd0, branch_cnt}, 32'd4);

        // 6: run both counters to all-ones, wrap, then reset during SQUASH
        issue(32'h240, 1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0);
        step();
        for (int i = 0; i < 11; i++) begin
            issue(32'h200, 1'b1, 30'h10, 1'b1, 1'b0, 1'b0, 30'h10);
            step();
        end
        check("t6_full_branch_cnt", {28'd0, branch_cnt}, 32'hF);
        check("t6_full_mispredict_cnt", {28'd0, mispredict_cnt}, 32'hF);
        issue(32'h200, 1'b1, 30'h10, 1'b1, 1'b0, 1'b0, 30'h10);
        check("t6_wrap_mispredict", {31'd0, mispredict}, 32'd1);
        check("t6_wrap_redirect", {2'd0, redirect_pc}, 32'h81);
        check("t6_wrap_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        check("t6_wrap_mispredict_cnt", {28'd0, mispredict_cnt}, 32'd0);
        step();
        issue(32'h200, 1'b1, 30'h10, 1'b1, 1'b0, 1'b0, 30'h10);
        check("t6_pre_rst_mispredict", {31'd0, mispredict}, 32'd1);
        check("t6_pre_rst_branch_cnt", {28'd0, branch_cnt}, 32'd1);
        rst = 1'b1;
        step();
        check_all_zero("t6_rst");
        rst = 1'b0;
        step();
        check("t6_post_rst_mispredict", {31'd0, mispredict}, 32'd0);
        check("t6_post_rst_branch_cnt", {28'd0, branch_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
